// File: rtl/pdl_pkg.sv
// Shared constants and state type for the pulse-delay generator.
// Optional feature macro: PDL_RETRIGGER_EN.
package pdl_pkg;

    localparam int PDL_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } pdl_state_t;

endpackage

// File: rtl/pdl_edge_det.sv
// Registered rising-edge detector for the trigger input.
// Synchronous active-high reset clears the history bit.
module pdl_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    output logic trig_edge
);

    logic trig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trigger;
        end
    end

    assign trig_edge = trigger & ~trig_q;

endmodule

// File: rtl/pdl_pulse_gen.sv
// Programmable pulse-delay generator: delay then one pulse of set width.
// Define PDL_RETRIGGER_EN to let a busy-time trigger restart the sequence.
module pdl_pulse_gen
    import pdl_pkg::*;
#(
    parameter int CNT_W = PDL_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] wb,
    input  logic [CNT_W-1:0] dl,
    input  logic             trigger,
    input  logic             enable,
    output logic             delay_out
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_DELAY = 2'(DELAY);
    localparam logic [1:0] ST_PULSE = 2'(PULSE);

    localparam logic [CNT_W-1:0] ONE  = 1;
    localparam logic [CNT_W-1:0] ZERO = '0;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wb_l;
    logic             trig_edge;

    pdl_edge_det u_edge (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .trig_edge (trig_edge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            delay_out <= 1'b0;
            cnt       <= ZERO;
            wb_l      <= ZERO;
        end else if (!enable) begin
            state     <= ST_IDLE;
            delay_out <= 1'b0;
`ifdef PDL_RETRIGGER_EN
        end else if (trig_edge && state != ST_IDLE) begin
            wb_l      <= wb;
            cnt       <= dl;
            state     <= ST_DELAY;
            delay_out <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (trig_edge) begin
                        wb_l  <= wb;
                        cnt   <= dl;
                        state <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (cnt != ZERO) begin
                        cnt <= cnt - ONE;
                    end else if (wb_l == ZERO) begin
                        state <= ST_IDLE;
                    end else begin
                        // Pulse already counts its first cycle here
                        state     <= ST_PULSE;
                        delay_out <= 1'b1;
                        cnt       <= wb_l - ONE;
                    end
                end
                ST_PULSE: begin
                    if (cnt != ZERO) begin
                        cnt <= cnt - ONE;
                    end else begin
                        state     <= ST_IDLE;
                        delay_out <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    delay_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pdl_pulse_gen.sv
// Randomized self-checking bench for pdl_pulse_gen.
// Reference model works on absolute edge numbers, not FSM states.
module tb_pdl_pulse_gen;

`ifdef PDL_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb = '0;
    logic [31:0] dl = '0;
    logic        trigger = 1'b0;
    logic        enable = 1'b1;
    logic        delay_out;

    int total = 0;
    int bad = 0;

    longint unsigned n = 0;
    bit              prev_trig = 1'b0;
    bit              active = 1'b0;
    longint unsigned rise_n = 0;
    longint unsigned fall_n = 0;
    longint unsigned acc_n = 0;
    bit              exp_out = 1'b0;

    pdl_pulse_gen #(.CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb        (wb),
        .dl        (dl),
        .trigger   (trigger),
        .enable    (enable),
        .delay_out (delay_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        bit edge_seen;
        bit idle;
        @(posedge clk);
        n++;
        if (reset) begin
            prev_trig = 1'b0;
            active    = 1'b0;
        end else begin
            edge_seen = trigger && !prev_trig;
            prev_trig = trigger;
            if (!enable) begin
                active = 1'b0;
            end else begin
                idle = !active || (n >= acc_n);
                if (edge_seen && (idle || RETRIG)) begin
                    active = 1'b1;
                    rise_n = n + longint'(dl) + 1;
                    fall_n = rise_n + longint'(wb);
                    acc_n  = n + longint'(dl) + 2 + longint'(wb);
                end
            end
        end
        exp_out = active && (rise_n <= n) && (n < fall_n);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        trigger = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (delay_out !== 1'b0) begin
                bad++;
                $display("FAIL reset n=%0d delay_out=%b want=0", n, delay_out);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        longint unsigned e0;
        longint unsigned first;
        int highs;
        dl = 10;
        wb = 10;
        trigger = 1'b1;
        tick();
        e0 = n;
        first = 0;
        highs = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 2) trigger = 1'b0;
            if (i > 0) tick();
            total++;
            if (delay_out !== exp_out) begin
                bad++;
                $display("FAIL basic n=%0d delay_out=%b want=%b", n, delay_out, exp_out);
            end
            if (delay_out === 1'b1) begin
                if (highs == 0) first = n;
                highs++;
            end
        end
        total++;
        if (first - e0 != 11) begin
            bad++;
            $display("FAIL basic_rise got=%0d want=11", first - e0);
        end
        total++;
        if (highs != 10) begin
            bad++;
            $display("FAIL basic_width got=%0d want=10", highs);
        end
    endtask

    task automatic test_param_change();
        longint unsigned e0;
        longint unsigned first;
        int highs;
        dl = 10;
        wb = 10;
        trigger = 1'b1;
        tick();
        for (int i = 1; i < 30; i++) begin
            if (i == 2) trigger = 1'b0;
            if (i == 5) begin
                dl = 18;
                wb = 16;
            end
            tick();
            total++;
            if (delay_out !== exp_out) begin
                bad++;
                $display("FAIL change1 n=%0d delay_out=%b want=%b", n, delay_out, exp_out);
            end
        end
        trigger = 1'b1;
        tick();
        e0 = n;
        first = 0;
        highs = 0;
        for (int i = 1; i < 45; i++) begin
            if (i == 3) trigger = 1'b0;
            tick();
            total++;
            if (delay_out !== exp_out) begin
                bad++;
                $display("FAIL change2 n=%0d delay_out=%b want=%b", n, delay_out, exp_out);
            end
            if (delay_out === 1'b1) begin
                if (highs == 0) first = n;
                highs++;
            end
        end
        total++;
        if (first - e0 != 19 || highs != 16) begin
            bad++;
            $display("FAIL change_next rise=%0d width=%0d want 19/16", first - e0, highs);
        end
    endtask

    task automatic test_busy_trigger();
        dl = 6;
        wb = 5;
        trigger = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            trigger = (i < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            total++;
            if (delay_out !== exp_out) begin
                bad++;
                $display("FAIL busy n=%0d delay_out=%b want=%b", n, delay_out, exp_out);
            end
        end
    endtask

    task automatic test_boundaries();
        int highs;
        dl = 0;
        wb = 1;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        total++;
        if (delay_out !== 1'b1) begin
            bad++;
            $display("FAIL dl0_rise delay_out=%b want=1", delay_out);
        end
        tick();
        total++;
        if (delay_out !== 1'b0) begin
            bad++;
            $display("FAIL dl0_fall delay_out=%b want=0", delay_out);
        end
        dl = 3;
        wb = 0;
        trigger = 1'b1;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            trigger = 1'b0;
            if (delay_out === 1'b1) highs++;
        end
        total++;
        if (highs != 0) begin
            bad++;
            $display("FAIL wb0 highs=%0d want=0", highs);
        end
        wb = 2;
        trigger = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            trigger = 1'b0;
            total++;
            if (delay_out !== exp_out) begin
                bad++;
                $display("FAIL wb0_next n=%0d delay_out=%b want=%b", n, delay_out, exp_out);
            end
        end
        dl = 32'hFFFF_FFFF;
        wb = 5;
        trigger = 1'b1;
        highs = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            trigger = 1'b0;
            if (delay_out !== 1'b0) highs++;
        end
        total++;
        if (highs != 0) begin
            bad++;
            $display("FAIL dl_max highs=%0d want=0", highs);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_abort_enable();
        int guard;
        dl = 2;
        wb = 8;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        guard = 0;
        while (delay_out !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        total++;
        if (delay_out !== 1'b1) begin
            bad++;
            $display("FAIL abort_en_start delay_out=%b want=1", delay_out);
        end
        tick();
        enable = 1'b0;
        tick();
        total++;
        if (delay_out !== 1'b0) begin
            bad++;
            $display("FAIL abort_en delay_out=%b want=0", delay_out);
        end
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (delay_out !== exp_out) begin
                bad++;
                $display("FAIL abort_en_after n=%0d delay_out=%b want=%b", n, delay_out, exp_out);
            end
        end
    endtask

    task automatic test_abort_reset();
        int highs;
        dl = 6;
        wb = 4;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (delay_out !== 1'b0) highs++;
        end
        total++;
        if (highs != 0) begin
            bad++;
            $display("FAIL abort_reset highs=%0d want=0", highs);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                dl = $urandom_range(0, 12);
                wb = $urandom_range(0, 8);
            end
            if ($urandom_range(0, 3) == 0) trigger = ~trigger;
            enable = ($urandom_range(0, 40) != 0);
            reset = ($urandom_range(0, 150) == 0);
            tick();
            total++;
            if (delay_out !== exp_out) begin
                bad++;
                $display("FAIL random n=%0d delay_out=%b want=%b", n, delay_out, exp_out);
            end
        end
        reset = 1'b0;
        enable = 1'b1;
        trigger = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_param_change();
        test_busy_trigger();
        test_boundaries();
        test_abort_enable();
        test_abort_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
